// File: rtl/axis_reduce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : axis_reduce_pkg                                              |
// | Description : Reduction operator encoding plus identity/combine helpers   |
// |               shared by the lane-reduce tree and the packet accumulator.  |
// |               Helpers work on a wide container; callers size-cast to the  |
// |               real lane width, which is passed in as argument w.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package axis_reduce_pkg;

  // Widest lane the helpers can handle; upper bits fold away in synthesis.
  localparam int unsigned C_LW_MAX = 256;

  typedef enum logic [1:0] {
    OP_MAX = 2'd0,
    OP_MIN = 2'd1,
    OP_SUM = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  // All-ones over the low w bits.
  function automatic logic [C_LW_MAX-1:0] lane_mask(input int unsigned w);
    if (w >= C_LW_MAX) return '1;
    return (C_LW_MAX'(1) << w) - C_LW_MAX'(1);
  endfunction

  // Sign bit of a w-bit lane.
  function automatic logic [C_LW_MAX-1:0] sign_bit(input int unsigned w);
    return C_LW_MAX'(1) << (w - 1);
  endfunction

  // Neutral element of each operator at lane width w.
  function automatic logic [C_LW_MAX-1:0] identity(input op_e op, input logic sgn,
                                                   input int unsigned w);
    case (op)
      OP_MAX:  return sgn ? sign_bit(w) : '0;
      OP_MIN:  return sgn ? (lane_mask(w) ^ sign_bit(w)) : lane_mask(w);
      default: return '0;
    endcase
  endfunction

  // Two-operand step. Operands must be zero above bit w-1. Signed compare is
  // done by flipping the sign bit, which maps two's complement order onto
  // unsigned order.
  function automatic logic [C_LW_MAX-1:0] combine(input op_e op, input logic sgn,
                                                  input logic [C_LW_MAX-1:0] a,
                                                  input logic [C_LW_MAX-1:0] b,
                                                  input int unsigned w);
    logic [C_LW_MAX-1:0] bias;
    logic [C_LW_MAX-1:0] a_key;
    logic [C_LW_MAX-1:0] b_key;
    bias  = sgn ? sign_bit(w) : '0;
    a_key = a ^ bias;
    b_key = b ^ bias;
    case (op)
      OP_MAX:  return (a_key >= b_key) ? a : b;
      OP_MIN:  return (a_key <= b_key) ? a : b;
      OP_SUM:  return (a + b) & lane_mask(w);
      default: return a ^ b;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_lane_reduce_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_lane_reduce_tree                                        |
// | Description : Combinational log2(N_LANES)-level reduction of one beat.    |
// |               Invalid lanes are replaced by the operator identity.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module axis_lane_reduce_tree
  import axis_reduce_pkg::*;
#(
  parameter int unsigned N_LANES = 8,
  parameter int unsigned LANE_W  = 64
) (
  input  op_e                         i_op,
  input  logic                        i_op_signed,
  input  logic [N_LANES*LANE_W-1:0]   i_lanes,
  input  logic [N_LANES-1:0]          i_valid,
  output logic [LANE_W-1:0]           o_result
);

  localparam int unsigned C_LEVELS = $clog2(N_LANES);

  logic [LANE_W-1:0] w_ident;

  assign w_ident = LANE_W'(identity(i_op, i_op_signed, LANE_W));

  // Level 0 holds the masked lanes; each further level halves the node count.
  for (genvar l = 0; l <= C_LEVELS; l++) begin : g_level
    localparam int unsigned C_NODES = N_LANES >> l;
    logic [C_NODES*LANE_W-1:0] w_val;

    if (l == 0) begin : g_leaves
      for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        assign w_val[i*LANE_W +: LANE_W] =
          i_valid[i] ? i_lanes[i*LANE_W +: LANE_W] : w_ident;
      end
    end else begin : g_combine
      for (genvar k = 0; k < C_NODES; k++) begin : g_pair
        assign w_val[k*LANE_W +: LANE_W] = LANE_W'(combine(i_op, i_op_signed,
          C_LW_MAX'(g_level[l-1].w_val[(2*k)*LANE_W +: LANE_W]),
          C_LW_MAX'(g_level[l-1].w_val[(2*k+1)*LANE_W +: LANE_W]),
          LANE_W));
      end
    end
  end

  assign o_result = g_level[C_LEVELS].w_val;

endmodule
`default_nettype wire

// File: rtl/axis_lane_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_lane_reduce                                             |
// | Description : Zero-latency AXI4-Stream pass-through with a per-packet     |
// |               lane reduction (MAX/MIN/SUM/XOR) on a handshaked result     |
// |               stream, plus beat/packet/stall statistics.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module axis_lane_reduce
  import axis_reduce_pkg::*;
#(
  parameter int unsigned N_LANES = 8,
  parameter int unsigned LANE_W  = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [1:0]                    op_mode,
  input  logic                          op_signed,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [N_LANES*LANE_W-1:0]     s_tdata,
  input  logic [N_LANES*LANE_W/8-1:0]   s_tkeep,
  input  logic                          s_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [N_LANES*LANE_W-1:0]     m_tdata,
  output logic [N_LANES*LANE_W/8-1:0]   m_tkeep,
  output logic                          m_tlast,
  output logic                          r_tvalid,
  input  logic                          r_tready,
  output logic [LANE_W-1:0]             r_tdata,
  output logic [CNT_W-1:0]              r_tbeats,
  input  logic                          stats_clr,
  output logic [CNT_W-1:0]              cnt_beats,
  output logic [CNT_W-1:0]              cnt_pkts,
  output logic [CNT_W-1:0]              cnt_stall
);

  op_e               r_op;
  logic              r_op_signed;
  logic              r_first;
  logic [LANE_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_beats;
  logic              r_res_valid;
  logic [LANE_W-1:0] r_res_data;
  logic [CNT_W-1:0]  r_res_beats;
  logic [CNT_W-1:0]  r_cnt_beats;
  logic [CNT_W-1:0]  r_cnt_pkts;
  logic [CNT_W-1:0]  r_cnt_stall;

  op_e               w_op;
  logic              w_op_signed;
  logic [N_LANES-1:0] w_lane_valid;
  logic [LANE_W-1:0] w_beat;
  logic [LANE_W-1:0] w_ident;
  logic [LANE_W-1:0] w_acc_in;
  logic [LANE_W-1:0] w_fold;
  logic [CNT_W-1:0]  w_beats_inc;
  logic              w_block;
  logic              w_accept;
  logic              w_res_take;

  // The first beat uses the live mode inputs; later beats use the latched copy.
  assign w_op        = r_first ? op_e'(op_mode) : r_op;
  assign w_op_signed = r_first ? op_signed      : r_op_signed;

  // A lane counts as valid when the keep bit of its lowest byte is set.
  for (genvar i = 0; i < N_LANES; i++) begin : g_valid
    assign w_lane_valid[i] = s_tkeep[i*LANE_W/8];
  end

  axis_lane_reduce_tree #(
    .N_LANES (N_LANES),
    .LANE_W  (LANE_W)
  ) u_tree (
    .i_op        (w_op),
    .i_op_signed (w_op_signed),
    .i_lanes     (s_tdata),
    .i_valid     (w_lane_valid),
    .o_result    (w_beat)
  );

  // Fold the beat into the running value; a first beat starts from identity
  // so nothing left over from a previous packet can leak in.
  assign w_ident     = LANE_W'(identity(w_op, w_op_signed, LANE_W));
  assign w_acc_in    = r_first ? w_ident : r_acc;
  assign w_fold      = LANE_W'(combine(w_op, w_op_signed, C_LW_MAX'(w_acc_in),
                                       C_LW_MAX'(w_beat), LANE_W));
  assign w_beats_inc = r_first ? CNT_W'(1)
                     : ((&r_beats) ? r_beats : r_beats + CNT_W'(1));

  // Only a last beat that would overwrite an unconsumed result is held off.
  assign w_block    = s_tlast & r_res_valid & ~r_tready;
  assign s_tready   = m_tready & ~w_block;
  assign m_tvalid   = s_tvalid & ~w_block;
  assign m_tdata    = s_tdata;
  assign m_tkeep    = s_tkeep;
  assign m_tlast    = s_tlast;
  assign w_accept   = s_tvalid & s_tready;
  assign w_res_take = r_res_valid & r_tready;

  assign r_tvalid  = r_res_valid;
  assign r_tdata   = r_res_data;
  assign r_tbeats  = r_res_beats;
  assign cnt_beats = r_cnt_beats;
  assign cnt_pkts  = r_cnt_pkts;
  assign cnt_stall = r_cnt_stall;

  // Packet accumulator: latch mode on the first beat, fold every accepted beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_first     <= 1'b1;
      r_op        <= OP_MAX;
      r_op_signed <= 1'b0;
      r_acc       <= '0;
      r_beats     <= '0;
    end else if (w_accept) begin
      if (r_first) begin
        r_op        <= w_op;
        r_op_signed <= w_op_signed;
      end
      if (s_tlast) begin
        r_first <= 1'b1;
        r_acc   <= w_ident;
        r_beats <= '0;
      end else begin
        r_first <= 1'b0;
        r_acc   <= w_fold;
        r_beats <= w_beats_inc;
      end
    end
  end

  // Result register: a new load wins over a consume in the same cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_beats <= '0;
    end else if (w_accept && s_tlast) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_fold;
      r_res_beats <= w_beats_inc;
    end else if (w_res_take) begin
      r_res_valid <= 1'b0;
    end
  end

  // Statistics counters; clear beats increment and leaves the datapath alone.
  always_ff @(posedge aclk) begin
    if (!aresetn || stats_clr) begin
      r_cnt_beats <= '0;
      r_cnt_pkts  <= '0;
      r_cnt_stall <= '0;
    end else begin
      if (w_accept)               r_cnt_beats <= r_cnt_beats + CNT_W'(1);
      if (w_res_take)             r_cnt_pkts  <= r_cnt_pkts + CNT_W'(1);
      if (s_tvalid && !s_tready)  r_cnt_stall <= r_cnt_stall + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_lane_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axis_lane_reduce                                          |
// | Description : Self-checking bench: directed packets with literal results   |
// |               followed by randomized traffic against a packet-level model.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_axis_lane_reduce;

  localparam int NL = 8;
  localparam int LW = 16;
  localparam int CW = 32;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [1:0]        op_mode = '0;
  logic              op_signed = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [NL*LW-1:0]  s_tdata = '0;
  logic [NL*LW/8-1:0] s_tkeep = '0;
  logic              s_tlast = 1'b0;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [NL*LW-1:0]  m_tdata;
  logic [NL*LW/8-1:0] m_tkeep;
  logic              m_tlast;
  logic              r_tvalid;
  logic              r_tready = 1'b0;
  logic [LW-1:0]     r_tdata;
  logic [CW-1:0]     r_tbeats;
  logic              stats_clr = 1'b0;
  logic [CW-1:0]     cnt_beats;
  logic [CW-1:0]     cnt_pkts;
  logic [CW-1:0]     cnt_stall;

  int n_err = 0;
  int n_checks = 0;
  bit rand_ready = 1'b0;

  axis_lane_reduce #(.N_LANES(NL), .LANE_W(LW), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .op_mode(op_mode), .op_signed(op_signed),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .r_tvalid(r_tvalid), .r_tready(r_tready),
    .r_tdata(r_tdata), .r_tbeats(r_tbeats), .stats_clr(stats_clr),
    .cnt_beats(cnt_beats), .cnt_pkts(cnt_pkts), .cnt_stall(cnt_stall)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet result from the plain rules: start at identity, apply op over valid lanes.
  function automatic logic [15:0] ref_reduce(input int op, input bit sgn,
                                             input logic [15:0] vals[$]);
    int acc;
    int v;
    case (op)
      0:       acc = sgn ? -32768 : 0;
      1:       acc = sgn ? 32767 : 65535;
      default: acc = 0;
    endcase
    foreach (vals[k]) begin
      v = sgn ? int'($signed(vals[k])) : int'(vals[k]);
      case (op)
        0:       if (v > acc) acc = v;
        1:       if (v < acc) acc = v;
        2:       acc = (acc + int'(vals[k])) % 65536;
        default: acc = acc ^ int'(vals[k]);
      endcase
    end
    return 16'(acc);
  endfunction

  // ---------------- behavioural model and per-cycle compare ----------------
  bit            e_rvalid = 1'b0;
  logic [15:0]   e_rdata = '0;
  logic [31:0]   e_rbeats = '0;
  logic [31:0]   e_cb = '0, e_cp = '0, e_cs = '0;
  bit            in_pkt = 1'b0;
  int            pkt_op = 0;
  bit            pkt_sgn = 1'b0;
  int            pkt_beats = 0;
  logic [15:0]   pkt_vals[$];

  always @(negedge aclk) begin
    bit blk, rdy, acc, take, stall;
    blk   = s_tlast & e_rvalid & ~r_tready;
    rdy   = m_tready & ~blk;
    acc   = s_tvalid & rdy;
    take  = e_rvalid & r_tready;
    stall = s_tvalid & ~rdy;
    check("s_tready", 128'(s_tready), 128'(rdy));
    check("m_tvalid", 128'(m_tvalid), 128'(s_tvalid & ~blk));
    check("m_tdata", 128'(m_tdata), 128'(s_tdata));
    check("m_tkeep", 128'(m_tkeep), 128'(s_tkeep));
    check("m_tlast", 128'(m_tlast), 128'(s_tlast));
    check("r_tvalid", 128'(r_tvalid), 128'(e_rvalid));
    check("r_tdata", 128'(r_tdata), 128'(e_rdata));
    check("r_tbeats", 128'(r_tbeats), 128'(e_rbeats));
    check("cnt_beats", 128'(cnt_beats), 128'(e_cb));
    check("cnt_pkts", 128'(cnt_pkts), 128'(e_cp));
    check("cnt_stall", 128'(cnt_stall), 128'(e_cs));
    if (!aresetn) begin
      e_rvalid = 0; e_rdata = '0; e_rbeats = '0;
      e_cb = '0; e_cp = '0; e_cs = '0;
      in_pkt = 0;
    end else begin
      if (acc) begin
        if (!in_pkt) begin
          pkt_op = int'(op_mode); pkt_sgn = op_signed;
          pkt_vals.delete(); pkt_beats = 0; in_pkt = 1;
        end
        for (int i = 0; i < NL; i++)
          if (s_tkeep[2*i]) pkt_vals.push_back(s_tdata[i*LW +: LW]);
        pkt_beats++;
      end
      if (acc && s_tlast) begin
        e_rdata  = ref_reduce(pkt_op, pkt_sgn, pkt_vals);
        e_rbeats = 32'(pkt_beats);
        e_rvalid = 1;
        in_pkt   = 0;
      end else if (take) begin
        e_rvalid = 0;
      end
      if (stats_clr) begin
        e_cb = '0; e_cp = '0; e_cs = '0;
      end else begin
        if (acc)   e_cb++;
        if (take)  e_cp++;
        if (stall) e_cs++;
      end
    end
  end

  // Random ready pattern for the randomized phase.
  always @(posedge aclk) begin
    if (rand_ready) begin
      #1;
      m_tready = ($urandom_range(0, 3) != 0);
      r_tready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send_beat(input logic [15:0] ln[8], input logic [15:0] keep, input bit last,
                           input logic [1:0] op, input bit sgn);
    int  n;
    bit  ok;
    for (int i = 0; i < NL; i++) s_tdata[i*LW +: LW] = ln[i];
    s_tkeep = keep; s_tlast = last; op_mode = op; op_signed = sgn; s_tvalid = 1'b1;
    n = 0; ok = 0;
    while (!ok && n < 1000) begin
      @(negedge aclk); ok = s_tready;
      @(posedge aclk); #1; n++;
    end
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL send_timeout: got no s_tready in %0d cycles, required acceptance", n);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic consume();
    r_tready = 1'b1; idle(1); r_tready = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [15:0] ln[8];
  logic [15:0] q[$];

  initial begin
    // Pin the reference model with hand-computed values.
    q.delete(); for (int i = 1; i <= 24; i++) q.push_back(16'(i));
    check("model_max_u", 128'(ref_reduce(0, 0, q)), 128'(24));
    q = '{16'd5, 16'hFFFD, 16'd7, 16'd0, 16'd1, 16'd2, 16'd3};
    check("model_min_s", 128'(ref_reduce(1, 1, q)), 128'(16'hFFFD));
    q.delete(); for (int i = 0; i < 16; i++) q.push_back(16'hFFFF);
    check("model_sum_wrap", 128'(ref_reduce(2, 0, q)), 128'(16'hFFF0));
    q.delete();
    check("model_empty_max_s", 128'(ref_reduce(0, 1, q)), 128'(16'h8000));

    idle(3); aresetn = 1'b1;
    @(negedge aclk);
    check("reset_r_tvalid", 128'(r_tvalid), 128'(0));
    check("reset_r_tdata", 128'(r_tdata), 128'(0));
    check("reset_cnt_beats", 128'(cnt_beats), 128'(0));
    idle(1);

    // MAX unsigned, 3 beats of values 1..24.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) ln[i] = 16'(b*8 + i + 1);
      send_beat(ln, 16'hFFFF, b == 2, 2'd0, 1'b0);
    end
    @(negedge aclk);
    check("t1_r_tvalid", 128'(r_tvalid), 128'(1));
    check("t1_r_tdata", 128'(r_tdata), 128'(24));
    check("t1_r_tbeats", 128'(r_tbeats), 128'(3));
    check("t1_cnt_beats", 128'(cnt_beats), 128'(3));
    idle(1); consume();
    @(negedge aclk);
    check("t1_cnt_pkts", 128'(cnt_pkts), 128'(1));
    check("t1_r_tvalid_clr", 128'(r_tvalid), 128'(0));
    idle(1);

    // MIN signed single beat, lane 3 (-9) masked off.
    ln = '{16'd5, 16'hFFFD, 16'd7, 16'hFFF7, 16'd0, 16'd1, 16'd2, 16'd3};
    send_beat(ln, 16'hFF3F, 1'b1, 2'd1, 1'b1);
    @(negedge aclk);
    check("t2_min_s", 128'(r_tdata), 128'(16'hFFFD));
    check("t2_beats", 128'(r_tbeats), 128'(1));
    idle(1); consume();
    // Mode changes to SUM on beat 2 must be ignored.
    ln = '{16'd4, 16'd8, 16'd12, 16'd16, 16'd20, 16'd24, 16'd28, 16'd32};
    send_beat(ln, 16'hFFFF, 1'b0, 2'd1, 1'b1);
    ln = '{16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'hFFFE};
    send_beat(ln, 16'hFFFF, 1'b1, 2'd2, 1'b0);
    @(negedge aclk);
    check("t2_mode_latched", 128'(r_tdata), 128'(16'hFFFE));
    idle(1); consume();

    // SUM wraps modulo 2^16.
    for (int i = 0; i < 8; i++) ln[i] = 16'hFFFF;
    send_beat(ln, 16'hFFFF, 1'b0, 2'd2, 1'b0);
    send_beat(ln, 16'hFFFF, 1'b1, 2'd2, 1'b0);
    @(negedge aclk);
    check("t3_sum_wrap", 128'(r_tdata), 128'(16'hFFF0));
    check("t3_beats", 128'(r_tbeats), 128'(2));
    idle(1);

    // Backpressure: result pending, XOR packet arrives, last beat must stall.
    ln = '{16'hA, 16'h5, 16'hA, 16'h5, 16'hA, 16'h5, 16'hA, 16'h5};
    send_beat(ln, 16'hFFFF, 1'b0, 2'd3, 1'b0);
    ln = '{16'hA, 16'h5, 16'h3, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < NL; i++) s_tdata[i*LW +: LW] = ln[i];
    s_tkeep = 16'hFFFF; s_tlast = 1'b1; op_mode = 2'd3; s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge aclk); check("t4_stall_ready", 128'(s_tready), 128'(0));
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    check("t4_cnt_stall", 128'(cnt_stall), 128'(3));
    @(posedge aclk); #1; r_tready = 1'b1;
    @(negedge aclk); check("t4_release_ready", 128'(s_tready), 128'(1));
    @(posedge aclk); #1; s_tvalid = 1'b0; s_tlast = 1'b0; r_tready = 1'b0;
    @(negedge aclk);
    check("t4_r_tvalid", 128'(r_tvalid), 128'(1));
    check("t4_xor", 128'(r_tdata), 128'(16'h000C));
    check("t4_cnt_pkts", 128'(cnt_pkts), 128'(4));
    check("t4_cnt_beats", 128'(cnt_beats), 128'(10));
    idle(1); consume();

    // stats_clr together with an accepted beat.
    for (int i = 0; i < 8; i++) s_tdata[i*LW +: LW] = 16'h7777;
    s_tkeep = 16'hFFFF; op_mode = 2'd0; op_signed = 1'b0; s_tvalid = 1'b1; stats_clr = 1'b1;
    @(negedge aclk); check("t5_ready", 128'(s_tready), 128'(1));
    @(posedge aclk); #1; s_tvalid = 1'b0; stats_clr = 1'b0;
    @(negedge aclk);
    check("t5_clr_beats", 128'(cnt_beats), 128'(0));
    check("t5_clr_pkts", 128'(cnt_pkts), 128'(0));
    idle(1);

    // Reset mid-packet discards the large partial maximum.
    for (int i = 0; i < 8; i++) ln[i] = 16'h7777;
    send_beat(ln, 16'hFFFF, 1'b0, 2'd0, 1'b0);
    aresetn = 1'b0; idle(2); aresetn = 1'b1;
    @(negedge aclk);
    check("t6_r_tvalid", 128'(r_tvalid), 128'(0));
    check("t6_cnt_beats", 128'(cnt_beats), 128'(0));
    idle(1);
    ln = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    send_beat(ln, 16'hFFFF, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) ln[i] = 16'd3;
    send_beat(ln, 16'hFFFF, 1'b1, 2'd0, 1'b0);
    @(negedge aclk);
    check("t6_after_reset", 128'(r_tdata), 128'(8));
    check("t6_beats", 128'(r_tbeats), 128'(2));
    idle(1); consume();
    // All-invalid packet yields identity (signed MIN -> most positive).
    for (int i = 0; i < 8; i++) ln[i] = 16'h1234;
    send_beat(ln, 16'h0000, 1'b1, 2'd1, 1'b1);
    @(negedge aclk);
    check("t6_all_invalid", 128'(r_tdata), 128'(16'h7FFF));
    idle(1); consume();

    // Randomized traffic, ready patterns and occasional statistics clears.
    rand_ready = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        logic [15:0] keep;
        for (int i = 0; i < 8; i++) ln[i] = pick();
        keep = 16'($urandom);
        if ($urandom_range(0, 15) == 0) keep = 16'h0000;
        stats_clr = ($urandom_range(0, 19) == 0);
        send_beat(ln, keep, b == len - 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        stats_clr = 1'b0;
        idle($urandom_range(0, 2));
      end
    end
    rand_ready = 1'b0;
    @(posedge aclk); #2;
    m_tready = 1'b1; r_tready = 1'b1;
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_lane_reduce.md
Name: axis_lane_reduce

Overview:
Parametrised per-packet lane reduction for host AXI4-Stream data. Each beat carries N_LANES lanes of LANE_W bits. The block passes every beat through unchanged with zero latency. In parallel it reduces all valid lanes of all beats in a packet (MAX, MIN, SUM or XOR; signed or unsigned) and emits one result per packet on a separate handshaked result stream. It sits between host sink/src and user logic and replaces a fixed 8x64 max reducer whose result port ignored backpressure; it also carries built-in stream statistics.

Parameters:
N_LANES, 8, number of lanes per beat (power of two, 1..16)
LANE_W, 64, lane width in bits (multiple of 8)
CNT_W, 32, width of statistics counters

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
op_mode  in  2  0=MAX, 1=MIN, 2=SUM, 3=XOR; sampled on first beat of packet
op_signed  in  1  signed compare for MAX/MIN; sampled with op_mode
s_tvalid  in  1  input beat valid
s_tready  out  1  input ready
s_tdata  in  N_LANES*LANE_W  input lanes, lane i at [i*LANE_W +: LANE_W]
s_tkeep  in  N_LANES*LANE_W/8  byte enables
s_tlast  in  1  end of packet
m_tvalid  out  1  pass-through valid
m_tready  in  1  pass-through ready
m_tdata  out  N_LANES*LANE_W  equals s_tdata
m_tkeep  out  N_LANES*LANE_W/8  equals s_tkeep
m_tlast  out  1  equals s_tlast
r_tvalid  out  1  result valid
r_tready  in  1  result ready
r_tdata  out  LANE_W  packet reduction value
r_tbeats  out  CNT_W  beats in the reduced packet
stats_clr  in  1  synchronous clear of statistics
cnt_beats  out  CNT_W  accepted input beats
cnt_pkts  out  CNT_W  results consumed (r handshakes)
cnt_stall  out  CNT_W  cycles with s_tvalid=1 and s_tready=0

Behaviour:
- Reset: r_tvalid=0, r_tdata=0, r_tbeats=0, all counters 0, accumulator at identity, first flag=1. m_tvalid follows s_tvalid and is gated as below.
- Block flag: block = s_tlast & r_tvalid & ~r_tready, i.e. a last beat arriving while the result register is still full. A non-last beat never blocks.
- Pass-through handshake: s_tready = m_tready & ~block; m_tvalid = s_tvalid & ~block. Data, keep and last are combinational (0 cycles). A beat is accepted when s_tvalid & s_tready.
- Lane validity: lane i is valid iff s_tkeep[i*LANE_W/8] = 1. Invalid lanes take the identity value:
  - MAX: 0 unsigned, most-negative signed
  - MIN: all-ones unsigned, most-positive signed
  - SUM and XOR: 0
- Reduction:
  - Each beat reduces combinationally across lanes and is then folded into the accumulator.
  - SUM wraps modulo 2^LANE_W.
  - On the first beat, op_mode and op_signed are latched and held until tlast. Changes mid-packet are ignored.
  - The first beat folds against identity, not against the stale accumulator.
- Packet end: on an accepted tlast beat, r_tdata <= fold(acc, beat), r_tbeats <= beats including this one, r_tvalid <= 1 on the next edge. The accumulator returns to identity and first returns to 1. Latency is 1 cycle from last-beat acceptance.
- A single-beat packet is both first and last in the same beat; its result is that beat's reduction.
- r_tvalid clears on r_tvalid & r_tready unless a new result loads in the same cycle; load wins. A load in the same cycle as a consume is allowed, since block=0 when r_tready=1.
- An all-invalid packet (every keep bit 0) produces the identity value.
- r_tbeats saturates at all-ones.
- Statistics:
  - Counters wrap at 2^CNT_W.
  - stats_clr takes priority over increment in the same cycle.
  - stats_clr does not touch the datapath.
- aresetn mid-packet discards the partial accumulation; no result is emitted for that packet.

Decomposition:
- Package axis_reduce_pkg: op enum (OP_MAX, OP_MIN, OP_SUM, OP_XOR); function identity(op, signed); function combine(op, signed, a, b).
- Sub-module axis_lane_reduce_tree: purely combinational log2(N_LANES)-level reduction of one beat using combine(). It is instantiated once; the top holds the accumulator, the handshake logic and the counters.

Test Plan:
- MAX unsigned, N=8, LANE_W=64: 3-beat packet with lanes 0..23, values 1..24, all keep=1 -> one result r_tdata=24, r_tbeats=3; m stream bit-identical; cnt_beats=3, cnt_pkts=1.
- MIN signed: single-beat packet, lanes {5,-3,7,-9,0,1,2,3}, keep masks off lane 3 -> r_tdata=-3; op_mode changed to SUM mid-packet in a 2-beat packet -> still reduces as MIN.
- SUM wrap, LANE_W=8: two beats of 8 lanes of 0xFF -> r_tdata=0xF0 (16*255 mod 256), r_tbeats=2.
- Backpressure: r_tready=0 with a result pending while the next packet arrives -> non-last beats pass, last beat stalls (s_tready=0, cnt_stall increments); raise r_tready -> old result consumed and new result loads on the same edge.
- Reset mid-packet: assert aresetn=0 after beat 2 of 4 -> no result emitted, counters 0; next packet yields a correct independent result.
- stats_clr asserted concurrently with an accepted beat -> cnt_beats=0 on the next cycle; XOR of lanes {0xA,0x5,...} checked against a model.
